// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  localparam int MEM_ARB_CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin on a tie; otherwise data always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output logic   valid,
  output owner_t owner
);

  assign valid = if_req | d_req;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    owner = OWN_D;
    if (if_req && d_req) begin
      // Tie goes to whoever was not served last.
      owner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
    end else if (if_req) begin
      owner = OWN_IF;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = (last_owner == OWN_D);
  assign owner = d_req ? OWN_D : OWN_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// MEM_ARB_RR_EN enables round-robin tie-breaking (default: data over fetch).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // state | meaning
  // IDLE  | sample requests, latch the winner
  // ISSUE | memory strobe and owner grant asserted
  // WAIT  | latency countdown, capture rdata on terminal count

  localparam logic [MEM_ARB_CNT_W-1:0] LAT_INIT = MEM_ARB_CNT_W'(MEM_LAT);
  localparam logic [MEM_ARB_CNT_W-1:0] CNT_ONE  = MEM_ARB_CNT_W'(1);

  state_t                   state, state_nxt;
  owner_t                   owner_q, last_owner, pick_owner;
  logic                     pick_valid;
  logic                     we_q;
  logic [MEM_ARB_CNT_W-1:0] cnt;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .owner      (pick_owner)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_D;
    end else if (state == IDLE && pick_valid) begin
      last_owner <= pick_owner;
    end
  end
`else
  assign last_owner = OWN_D;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == CNT_ONE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the decision made in the preceding cycle,
  // so the mem_* strobes are high exactly while the FSM sits in ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner_q   <= OWN_D;
      we_q      <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_owner;
            mem_en  <= 1'b1;
            if (pick_owner == OWN_D) begin
              we_q      <= d_we;
              d_gnt     <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              we_q     <= 1'b0;
              if_gnt   <= 1'b1;
              mem_addr <= if_addr;
            end
          end
        end
        ISSUE: cnt <= LAT_INIT;
        WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            if (owner_q == OWN_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= we_q ? '0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with MEM_LAT=2 and a behavioural memory.
// Tie expectations follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;

  typedef struct {
    bit                is_d;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage read pipeline: data read in the mem_en cycle appears MEM_LAT=2 cycles later.
  logic [DATA_W-1:0] mem_arr [0:255];
  bit                written [0:255];
  logic [DATA_W-1:0] rd_s1 = '0;

  function automatic logic [DATA_W-1:0] init_val(input logic [7:0] idx);
    if (idx == 8'd4) return 32'h0050_0093;
    if (idx == 8'd8) return 32'h1111_2222;
    return {24'h0, idx};
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      rd_s1 <= written[mem_addr[9:2]] ? mem_arr[mem_addr[9:2]] : init_val(mem_addr[9:2]);
      if (mem_we) begin
        mem_arr[mem_addr[9:2]] <= mem_wdata;
        written[mem_addr[9:2]] <= 1'b1;
      end
    end
    mem_rdata <= rd_s1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the next response pulse and pops the scoreboard entry it should match.
  task automatic wait_resp(input int budget, output bit got, output int when,
                           output bit act_is_d, output logic [DATA_W-1:0] act_data,
                           output bit have_exp, output exp_t e);
    got = 0; when = -1; act_is_d = 0; act_data = '0; have_exp = 0;
    e = '{is_d: 1'b0, data: '0};
    for (int i = 0; i < budget; i++) begin
      step();
      if (if_rvalid || d_rvalid) begin
        got = 1;
        when = cyc;
        act_is_d = d_rvalid;
        act_data = d_rvalid ? d_rdata : if_rdata;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          have_exp = 1;
        end
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 16'h0010; d_addr = 16'h0100; d_wdata = 32'hA5A5_A5A5;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({busy, mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 7'b0) begin
        n_bad++;
        $display("FAIL reset_ctrl cycle %0d: got %b want 0000000", k,
                 {busy, mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid});
      end
      n_cmp++;
      if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
        n_bad++;
        $display("FAIL reset_data cycle %0d: addr %h wdata %h if_rdata %h d_rdata %h want 0",
                 k, mem_addr, mem_wdata, if_rdata, d_rdata);
      end
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    rst = 1'b0;
    step(); step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_fetch();
    int t0, when; bit got, is_d, he; logic [DATA_W-1:0] dat; exp_t e;
    step(); t0 = cyc;
    if_addr = 16'h0010; if_req = 1'b1;
    sb.push_back('{is_d: 1'b0, data: 32'h0050_0093});
    step();
    n_cmp++;
    if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 16'h0010) begin
      n_bad++;
      $display("FAIL fetch_issue: gnt/en/we %b addr %h want 1010 addr 0010",
               {if_gnt, d_gnt, mem_en, mem_we}, mem_addr);
    end
    if_req = 1'b0;
    wait_resp(10, got, when, is_d, dat, he, e);
    n_cmp++;
    if (!got || when - t0 != 4 || is_d) begin
      n_bad++;
      $display("FAIL fetch_rvalid_cycle: got cycle %0d d=%b want cycle 4 fetch", when - t0, is_d);
    end
    n_cmp++;
    if (!he || dat !== e.data || is_d !== e.is_d) begin
      n_bad++;
      $display("FAIL fetch_rdata: got %h want %h", dat, e.data);
    end
  endtask

  task automatic test_store();
    int t0, when; bit got, is_d, he; logic [DATA_W-1:0] dat; exp_t e;
    step(); t0 = cyc;
    d_we = 1'b1; d_addr = 16'h0100; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    sb.push_back('{is_d: 1'b1, data: 32'h0});
    step();
    n_cmp++;
    if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b0111 || mem_addr !== 16'h0100) begin
      n_bad++;
      $display("FAIL store_issue: gnt/en/we %b addr %h want 0111 addr 0100",
               {if_gnt, d_gnt, mem_en, mem_we}, mem_addr);
    end
    n_cmp++;
    if (mem_wdata !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL store_wdata: got %h want deadbeef", mem_wdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    wait_resp(10, got, when, is_d, dat, he, e);
    n_cmp++;
    if (!got || when - t0 != 4 || !is_d) begin
      n_bad++;
      $display("FAIL store_rvalid_cycle: got cycle %0d d=%b want cycle 4 data", when - t0, is_d);
    end
    n_cmp++;
    if (!he || dat !== e.data) begin
      n_bad++;
      $display("FAIL store_rdata: got %h want %h", dat, e.data);
    end
  endtask

  task automatic test_tie();
    int t0, g_if, g_d, n_resp, exp_g_if, exp_g_d;
    exp_t e;
    step(); t0 = cyc;
    if_addr = 16'h0010; d_addr = 16'h0020; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
`ifdef MEM_ARB_RR_EN
    exp_g_if = 1; exp_g_d = 5;
    sb.push_back('{is_d: 1'b0, data: 32'h0050_0093});
    sb.push_back('{is_d: 1'b1, data: 32'h1111_2222});
`else
    exp_g_if = 5; exp_g_d = 1;
    sb.push_back('{is_d: 1'b1, data: 32'h1111_2222});
    sb.push_back('{is_d: 1'b0, data: 32'h0050_0093});
`endif
    g_if = -1; g_d = -1; n_resp = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (if_gnt && g_if < 0) begin g_if = cyc - t0; if_req = 1'b0; end
      if (d_gnt && g_d < 0) begin g_d = cyc - t0; d_req = 1'b0; end
      if (if_rvalid || d_rvalid) begin
        n_resp++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL tie_resp: unexpected response at cycle %0d", cyc - t0);
        end else begin
          e = sb.pop_front();
          if (d_rvalid !== e.is_d || (e.is_d ? d_rdata : if_rdata) !== e.data) begin
            n_bad++;
            $display("FAIL tie_resp: got d=%b data %h want d=%b data %h", d_rvalid,
                     d_rvalid ? d_rdata : if_rdata, e.is_d, e.data);
          end
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    n_cmp++;
    if (g_d != exp_g_d) begin
      n_bad++;
      $display("FAIL tie_d_gnt_cycle: got %0d want %0d", g_d, exp_g_d);
    end
    n_cmp++;
    if (g_if != exp_g_if) begin
      n_bad++;
      $display("FAIL tie_if_gnt_cycle: got %0d want %0d", g_if, exp_g_if);
    end
    n_cmp++;
    if (n_resp != 2) begin
      n_bad++;
      $display("FAIL tie_resp_count: got %0d want 2", n_resp);
    end
  endtask

  task automatic test_back_to_back();
    int n_gnt, n_resp;
    bit exp_busy, exp_gnt;
    exp_t e;
    step();
    d_we = 1'b0; d_addr = 16'h0100; d_req = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back('{is_d: 1'b1, data: 32'hDEAD_BEEF});
    n_gnt = 0; n_resp = 0;
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) step();
      exp_busy = !(k == 0 || k == 4 || k == 8 || k >= 12);
      exp_gnt  = (k == 1 || k == 5 || k == 9);
      n_cmp++;
      if (busy !== exp_busy) begin
        n_bad++;
        $display("FAIL b2b_busy cycle %0d: got %b want %b", k, busy, exp_busy);
      end
      n_cmp++;
      if (d_gnt !== exp_gnt) begin
        n_bad++;
        $display("FAIL b2b_gnt cycle %0d: got %b want %b", k, d_gnt, exp_gnt);
      end
      if (d_gnt === 1'b1) begin
        n_gnt++;
        if (n_gnt == 3) d_req = 1'b0;
      end
      if (d_rvalid === 1'b1) begin
        n_resp++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_rdata: unexpected response at cycle %0d", k);
        end else begin
          e = sb.pop_front();
          if (d_rdata !== e.data) begin
            n_bad++;
            $display("FAIL b2b_rdata cycle %0d: got %h want %h", k, d_rdata, e.data);
          end
        end
      end
    end
    d_req = 1'b0;
    n_cmp++;
    if (n_resp != 3) begin
      n_bad++;
      $display("FAIL b2b_resp_count: got %0d want 3", n_resp);
    end
  endtask

  task automatic test_reset_wait();
    int t0, when, n_spur; bit got, is_d, he; logic [DATA_W-1:0] dat; exp_t e;
    // Reset while the strobe is up: it must drop without waiting for a clock edge.
    step();
    if_addr = 16'h0010; if_req = 1'b1;
    step();
    n_cmp++;
    if (mem_en !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_issue_pre: mem_en got %b want 1", mem_en);
    end
    if_req = 1'b0; rst = 1'b1;
    #1;
    n_cmp++;
    if ({mem_en, if_gnt, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_issue_async: en/gnt/busy got %b want 000", {mem_en, if_gnt, busy});
    end
    step(); rst = 1'b0;
    // Reset in WAIT (cycle 2).
    step();
    if_req = 1'b1;
    step();
    if_req = 1'b0;
    step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({mem_en, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_wait_async: en/busy got %b want 00", {mem_en, busy});
    end
    step(); rst = 1'b0;
    n_spur = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (if_rvalid || d_rvalid) n_spur++;
    end
    n_cmp++;
    if (n_spur != 0) begin
      n_bad++;
      $display("FAIL rst_wait_no_rvalid: got %0d pulses want 0", n_spur);
    end
    step(); t0 = cyc;
    d_we = 1'b0; d_addr = 16'h0020; d_req = 1'b1;
    sb.push_back('{is_d: 1'b1, data: 32'h1111_2222});
    step();
    d_req = 1'b0;
    wait_resp(10, got, when, is_d, dat, he, e);
    n_cmp++;
    if (!got || when - t0 != 4 || !is_d) begin
      n_bad++;
      $display("FAIL rst_resume_cycle: got cycle %0d d=%b want cycle 4 data", when - t0, is_d);
    end
    n_cmp++;
    if (!he || dat !== e.data) begin
      n_bad++;
      $display("FAIL rst_resume_rdata: got %h want %h", dat, e.data);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      written[i] = 1'b0;
      mem_arr[i] = '0;
    end
    test_reset();
    test_fetch();
    test_store();
    test_tie();
    test_back_to_back();
    test_reset_wait();
    step(); step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
